// File: rtl/proj_lane_chk_pkg.sv
// Shared definitions for the lane checker: default widths and FSM state encoding.
// The lane generator and the checker both read their default W/EW values from here.
package proj_lane_chk_pkg;

  localparam int DEF_W  = 16;
  localparam int DEF_EW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } chk_state_e;

endpackage

// File: rtl/proj_lane_chk_rdy_throttle.sv
// Ready throttle: rdy is high for X cycles, then low for one cycle (X=0: always high).
// The pattern starts on the first enabled edge, so phase 0 lines up with the first ready cycle.
module proj_rdy_throttle #(
  parameter int X = 2
) (
  input  logic chkclk,
  input  logic chkrst,
  input  logic en,
  output logic rdy
);

  localparam int TW = (X < 1) ? 1 : $clog2(X + 1);

  logic [TW-1:0] thr;

  always_ff @(posedge chkclk or posedge chkrst) begin
    if (chkrst) begin
      thr <= '0;
      rdy <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking, so rdy is decoded from thr as it was before this edge;
      // rdy is therefore a registered copy of (thr < X) for the phase just entered.
      rdy <= (X == 0) || (thr < TW'(X));
      thr <= (thr == TW'(X)) ? '0 : thr + 1'b1;
    end
  end

endmodule

// File: rtl/proj_lane_chk.sv
// Lane checker: drains the async FIFO read port through a throttled handshake and
// compares each word against a regenerated incrementing sequence, counting mismatches.
module proj_lane_chk
  import proj_lane_chk_pkg::*;
#(
  parameter int    W    = DEF_W,
  parameter int    EW   = DEF_EW,
  parameter int    X    = 2,
  parameter int    EDBG = 0,
  parameter string ID   = "LANE"
) (
  input  logic          chkclk,
  input  logic          chkrst,
  input  logic [W-1:0]  rddata,
  input  logic          rdvld,
  output logic          rdrdy,
  output logic [EW-1:0] errcntr,
  output logic          lock,
  output logic [31:0]   rxcnt
);

  localparam logic [EW-1:0] ERR_MAX = '1;

  chk_state_e   state;
  chk_state_e   state_nxt;
  logic [W-1:0] exp;
  logic         xfer;
  logic         thr_en;
  logic         seq_load;
  logic         mismatch;

  assign xfer = rdvld & rdrdy;

  proj_rdy_throttle #(
    .X(X)
  ) u_thr (
    .chkclk(chkclk),
    .chkrst(chkrst),
    .en    (thr_en),
    .rdy   (rdrdy)
  );

  always_ff @(posedge chkclk or posedge chkrst) begin
    if (chkrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: default first, so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_SYNC;
      ST_SYNC:  if (xfer) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_CHECK;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    thr_en   = (state != ST_IDLE);
    seq_load = 1'b0;
    mismatch = 1'b0;
    case (state)
      ST_SYNC:  seq_load = xfer;
      ST_CHECK: mismatch = xfer && (rddata != exp);
      default:  ;
    endcase
  end

  always_ff @(posedge chkclk or posedge chkrst) begin
    if (chkrst) begin
      exp     <= '0;
      errcntr <= '0;
      lock    <= 1'b0;
      rxcnt   <= '0;
    end else begin
      // Lock, match and resync all leave the expected value at the word just seen plus one.
      if (xfer) begin
        rxcnt <= rxcnt + 32'd1;
        exp   <= rddata + 1'b1;
      end
      if (seq_load) begin
        lock <= 1'b1;
      end
      if (mismatch && (errcntr != ERR_MAX)) begin
        errcntr <= errcntr + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  if (EDBG != 0) begin : g_dbg
    always_ff @(posedge chkclk) begin
      if (!chkrst && mismatch) begin
        $display("%s: sequence error exp=%0h got=%0h rxcnt=%0d", ID, exp, rddata, rxcnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_proj_lane_chk.sv
// Randomized bench for proj_lane_chk: a transfer-level model predicts ready pattern,
// lock, error count and word count; a second instance with X=0 checks the always-ready case.
module tb_proj_lane_chk;

  logic        chkclk = 1'b0;
  logic        chkrst = 1'b1;
  logic [15:0] rddata = '0;
  logic        rdvld  = 1'b0;

  logic        rdrdy,    rdrdy0;
  logic        lock,     lock0;
  logic [7:0]  errcntr,  errcntr0;
  logic [31:0] rxcnt,    rxcnt0;

  always #5 chkclk = ~chkclk;

  proj_lane_chk #(.W(16), .EW(8), .X(2), .EDBG(0), .ID("LANE")) dut (
    .chkclk (chkclk),
    .chkrst (chkrst),
    .rddata (rddata),
    .rdvld  (rdvld),
    .rdrdy  (rdrdy),
    .errcntr(errcntr),
    .lock   (lock),
    .rxcnt  (rxcnt)
  );

  proj_lane_chk #(.W(16), .EW(8), .X(0), .EDBG(0), .ID("LANE0")) dut0 (
    .chkclk (chkclk),
    .chkrst (chkrst),
    .rddata (rddata),
    .rdvld  (rdvld),
    .rdrdy  (rdrdy0),
    .errcntr(errcntr0),
    .lock   (lock0),
    .rxcnt  (rxcnt0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edges since reset release, plus the lane's observable results.
  int          cyc;
  bit          m_lock;
  logic [15:0] m_exp;
  int          m_err;
  logic [31:0] m_rx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Ready after edge k: low at edge 1 (leaving IDLE), then X high / 1 low from edge 2 on.
  function automatic bit m_rdy(input int k, input int x);
    if (k < 2) return 1'b0;
    if (x == 0) return 1'b1;
    return ((k - 2) % (x + 1)) != x;
  endfunction

  task automatic model_reset();
    cyc    = 0;
    m_lock = 1'b0;
    m_exp  = '0;
    m_err  = 0;
    m_rx   = '0;
  endtask

  // Called at a falling edge; presents one cycle of input and checks the result.
  task automatic cycle(input bit vld, input logic [15:0] data, output bit took);
    bit rdy_now;
    rdvld   = vld;
    rddata  = data;
    rdy_now = m_rdy(cyc, 2);
    check("rdrdy", rdrdy, rdy_now);
    check("rdrdy_x0", rdrdy0, m_rdy(cyc, 0));
    took = vld && rdy_now;
    @(posedge chkclk);
    cyc++;
    if (took) begin
      m_rx++;
      if (!m_lock) m_lock = 1'b1;
      else if (data != m_exp && m_err < 255) m_err++;
      m_exp = data + 16'd1;
    end
    @(negedge chkclk);
    check("lock", lock, m_lock);
    check("errcntr", errcntr, m_err);
    check("rxcnt", rxcnt, m_rx);
  endtask

  task automatic send_words(input logic [15:0] words[$], input int gap_pct);
    int idx    = 0;
    int budget = words.size() * 4 + 20;
    bit vld, took;
    while (idx < words.size() && budget > 0) begin
      vld = ($urandom_range(0, 99) >= gap_pct);
      cycle(vld, vld ? words[idx] : 16'($urandom), took);
      if (took) idx++;
      budget--;
    end
    if (idx < words.size()) check("send_timeout", idx, words.size());
  endtask

  // Reset pulse raised between edges with a word presented; outputs must clear at once.
  task automatic apply_reset();
    chkrst = 1'b1;
    rdvld  = 1'b1;
    rddata = 16'($urandom);
    #1;
    check("rst_rdrdy", rdrdy, 0);
    check("rst_rdrdy_x0", rdrdy0, 0);
    check("rst_errcntr", errcntr, 0);
    check("rst_lock", lock, 0);
    check("rst_rxcnt", rxcnt, 0);
    model_reset();
    @(posedge chkclk);
    @(negedge chkclk);
    chkrst = 1'b0;
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] v;
    int          lows;
    bit          took;

    model_reset();
    @(negedge chkclk);
    apply_reset();

    // Continuous stream from 0x0005: ready pattern 0,1,1,0,... and no errors.
    q = {};
    for (int i = 0; i < 256; i++) q.push_back(16'h0005 + 16'(i));
    send_words(q, 0);
    check("s1_rxcnt", rxcnt, 256);
    check("s1_errcntr", errcntr, 0);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 16'($urandom), took);
      if (!rdrdy) lows++;
    end
    check("s1_rdy_lows", lows, 10);

    // Sequence wrap is a match.
    apply_reset();
    q = {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    send_words(q, 30);
    check("s2_errcntr", errcntr, 0);
    check("s2_lock", lock, 1);

    // One jump, then resync: a single error.
    apply_reset();
    q = {16'h0010, 16'h0011, 16'h0020, 16'h0021};
    send_words(q, 30);
    check("s3_errcntr", errcntr, 1);
    check("s3_rxcnt", rxcnt, 4);

    // 300 mismatches in a row saturate the counter, and further ones hold it.
    apply_reset();
    q = {};
    v = 16'h0100;
    q.push_back(v);
    for (int i = 0; i < 300; i++) begin
      v = v + 16'd2;
      q.push_back(v);
    end
    send_words(q, 20);
    check("s4_errcntr_sat", errcntr, 255);
    q = {16'h0001, 16'h0007, 16'h0008};
    send_words(q, 20);
    check("s4_errcntr_hold", errcntr, 255);

    // Three errors, then a mid-stream reset, then relock without an error.
    apply_reset();
    q = {16'h0040, 16'h0041, 16'h0050, 16'h0060, 16'h0070, 16'h0071};
    send_words(q, 25);
    check("s5_errcntr_pre", errcntr, 3);
    apply_reset();
    q = {16'h1234, 16'h1235};
    send_words(q, 25);
    check("s5_errcntr_post", errcntr, 0);
    check("s5_lock_post", lock, 1);
    check("s5_rxcnt_post", rxcnt, 2);

    // Random traffic: mostly in sequence, with occasional jumps and idle gaps.
    apply_reset();
    q = {};
    v = 16'($urandom);
    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 9) < 8) ? v + 16'd1 : 16'($urandom);
      q.push_back(v);
    end
    send_words(q, 25);
    check("s6_rxcnt", rxcnt, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
